// File: rtl/datamem_responder_if.sv
// Load/store port between the datapath and the data-memory responder:
// a request handshake and a response handshake.
interface datamem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic [3:0]  req_size;
  logic        resp_valid;
  logic        resp_ready;
  logic [63:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_size, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_size, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/datamem_responder.sv
// Fixed-latency byte-addressed data memory behind a valid/ready request and
// response pair; illegal accesses are reported and leave storage untouched.
module datamem_responder #(
  parameter int DEPTH_BYTES = 1024,
  parameter int LATENCY     = 3
) (
  input  logic                clk,
  input  logic                reset,
  datamem_responder_if.slave  bus
);
  localparam int AW = $clog2(DEPTH_BYTES);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  typedef struct packed {
    logic        write;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [3:0]  size;
  } req_t;

  state_t        state;
  logic [CW-1:0] cnt;
  req_t          req_q;
  logic [63:0]   rdata_q;
  logic          err_q;

  // Zero at time zero only; reset deliberately leaves contents alone.
  logic [7:0] mem [DEPTH_BYTES] = '{default: 8'h00};

  logic          size_ok, aligned, in_range, illegal;
  logic [64:0]   end_addr;
  logic [AW-1:0] base;
  logic [63:0]   rd_word;
  logic          access, mem_we;

  // 65-bit end address so requests near 2^64 cannot wrap into range.
  always_comb begin
    size_ok  = req_q.size inside {4'd1, 4'd2, 4'd4, 4'd8};
    aligned  = (req_q.addr & (64'(req_q.size) - 64'd1)) == 64'd0;
    end_addr = {1'b0, req_q.addr} + 65'(req_q.size);
    in_range = end_addr <= 65'(DEPTH_BYTES);
    illegal  = !(size_ok && aligned && in_range);
  end

  assign base = req_q.addr[AW-1:0];

  always_comb begin
    rd_word = '0;
    for (int i = 0; i < 8; i++)
      if (4'(i) < req_q.size) rd_word[8*i +: 8] = mem[base + AW'(i)];
  end

  assign access = (state == BUSY) && (cnt == '0);
  assign mem_we = reset && access && req_q.write && !illegal;

  always_ff @(posedge clk) begin
    if (mem_we)
      for (int i = 0; i < 8; i++)
        if (4'(i) < req_q.size) mem[base + AW'(i)] <= req_q.wdata[8*i +: 8];
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.req_valid) begin
          req_q <= '{write: bus.req_write, addr: bus.req_addr,
                     wdata: bus.req_wdata, size: bus.req_size};
          cnt   <= CW'(LATENCY - 1);
          state <= BUSY;
        end
        BUSY: if (cnt != '0) begin
          cnt <= cnt - 1'b1;
        end else begin
          err_q   <= illegal;
          rdata_q <= (illegal || req_q.write) ? 64'd0 : rd_word;
          state   <= RESP;
        end
        RESP: if (bus.resp_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready  = (state == IDLE);
  assign bus.resp_valid = (state == RESP);
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;
endmodule

// File: tb/tb_datamem_responder.sv
// Directed table plus randomized traffic against a byte-array reference model.
module tb_datamem_responder;
  localparam int DEPTH = 1024;
  localparam int LAT   = 3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  datamem_responder_if bus ();

  datamem_responder #(.DEPTH_BYTES(DEPTH), .LATENCY(LAT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference model: plain byte array updated from the access rules.
  logic [7:0] mdl [DEPTH];

  function automatic void model(input logic w, input logic [63:0] a, input logic [63:0] d,
                                input logic [3:0] s, output logic [63:0] r, output logic e);
    longint unsigned ua, us;
    ua = a;
    us = 64'(s);
    r  = '0;
    e  = !(s == 4'd1 || s == 4'd2 || s == 4'd4 || s == 4'd8);
    if (!e) e = ((ua % us) != 0) || (ua > 64'(DEPTH) - us);
    if (e) return;
    for (int i = 0; i < int'(s); i++) begin
      if (w) mdl[ua + 64'(i)] = d[8*i +: 8];
      else   r = r | (64'(mdl[ua + 64'(i)]) << (8*i));
    end
  endfunction

  task automatic xact(input string nm, input logic w, input logic [63:0] a, input logic [63:0] d,
                      input logic [3:0] s, input int bp, input logic [63:0] er, input logic ee);
    int cyc;
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_write  = w;
    bus.req_addr   = a;
    bus.req_wdata  = d;
    bus.req_size   = s;
    bus.resp_ready = 1'b0;
    cyc = 0;
    while (!bus.req_ready && cyc < 20) begin @(negedge clk); cyc++; end
    chk({nm, " req_ready"}, 64'(bus.req_ready), 64'd1);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    cyc = 0;
    while (!bus.resp_valid && cyc < 50) begin @(posedge clk); #1; cyc++; end
    chk({nm, " latency"}, 64'(cyc), 64'(LAT));
    if (!bus.resp_valid) return;
    chk({nm, " rdata"}, bus.resp_rdata, er);
    chk({nm, " err"}, 64'(bus.resp_err), 64'(ee));
    for (int k = 0; k < bp; k++) begin
      @(posedge clk); #1;
      chk({nm, " hold valid"}, 64'(bus.resp_valid), 64'd1);
      chk({nm, " hold rdata"}, bus.resp_rdata, er);
      chk({nm, " hold err"}, 64'(bus.resp_err), 64'(ee));
      chk({nm, " hold req_ready"}, 64'(bus.req_ready), 64'd0);
    end
    bus.resp_ready = 1'b1;
    @(posedge clk); #1;
    bus.resp_ready = 1'b0;
    chk({nm, " resp_valid drop"}, 64'(bus.resp_valid), 64'd0);
    chk({nm, " req_ready back"}, 64'(bus.req_ready), 64'd1);
  endtask

  typedef struct {
    logic        w;
    logic [63:0] a;
    logic [63:0] d;
    logic [3:0]  s;
    int          bp;
    logic [63:0] er;
    logic        ee;
  } vec_t;

  vec_t tbl[$];

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] r;
    logic        e;
    logic [3:0]  sz_opts [7];
    for (int i = 0; i < DEPTH; i++) mdl[i] = 8'h00;
    sz_opts = '{4'd1, 4'd2, 4'd4, 4'd8, 4'd8, 4'd3, 4'd0};

    // Reset held with a store presented: it must not be taken.
    reset          = 1'b0;
    bus.req_valid  = 1'b1;
    bus.req_write  = 1'b1;
    bus.req_addr   = 64'h40;
    bus.req_wdata  = '1;
    bus.req_size   = 4'd8;
    bus.resp_ready = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
      chk("rst resp_valid", 64'(bus.resp_valid), 64'd0);
    end
    @(negedge clk);
    bus.req_valid = 1'b0;
    reset         = 1'b1;
    @(posedge clk); #1;
    chk("post-rst req_ready", 64'(bus.req_ready), 64'd1);
    chk("post-rst resp_valid", 64'(bus.resp_valid), 64'd0);

    // Reset while BUSY drops the store.
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_write = 1'b1;
    bus.req_addr  = 64'h20;
    bus.req_wdata = 64'hDEAD;
    bus.req_size  = 4'd2;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    chk("midrst busy req_ready", 64'(bus.req_ready), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("midrst resp_valid", 64'(bus.resp_valid), 64'd0);
    chk("midrst req_ready", 64'(bus.req_ready), 64'd1);
    @(negedge clk);
    reset = 1'b1;
    repeat (LAT + 3) begin
      @(posedge clk); #1;
      chk("midrst no resp", 64'(bus.resp_valid), 64'd0);
    end
    xact("midrst reload", 1'b0, 64'h20, 64'd0, 4'd8, 0, 64'd0, 1'b0);
    xact("rst-store dropped", 1'b0, 64'h40, 64'd0, 4'd8, 0, 64'd0, 1'b0);

    tbl.push_back('{1'b1, 64'h10, 64'h1122334455667788, 4'd8, 0, 64'd0, 1'b0});
    tbl.push_back('{1'b0, 64'h10, 64'd0, 4'd8, 0, 64'h1122334455667788, 1'b0});
    tbl.push_back('{1'b0, 64'h12, 64'd0, 4'd2, 0, 64'h5566, 1'b0});
    tbl.push_back('{1'b1, 64'h11, 64'hAB, 4'd1, 0, 64'd0, 1'b0});
    tbl.push_back('{1'b0, 64'h10, 64'd0, 4'd8, 0, 64'h112233445566AB88, 1'b0});
    tbl.push_back('{1'b0, 64'h13, 64'd0, 4'd4, 0, 64'd0, 1'b1});
    tbl.push_back('{1'b1, 64'(DEPTH - 4), 64'hFFFF_FFFF_FFFF_FFFF, 4'd8, 0, 64'd0, 1'b1});
    tbl.push_back('{1'b0, 64'h0, 64'd0, 4'd3, 0, 64'd0, 1'b1});
    tbl.push_back('{1'b0, 64'hFFFF_FFFF_FFFF_FFF8, 64'd0, 4'd8, 0, 64'd0, 1'b1});
    tbl.push_back('{1'b1, 64'h10, 64'hFFFF_FFFF_FFFF_FFFF, 4'd0, 0, 64'd0, 1'b1});
    tbl.push_back('{1'b0, 64'h10, 64'd0, 4'd8, 5, 64'h112233445566AB88, 1'b0});
    tbl.push_back('{1'b0, 64'(DEPTH - 8), 64'd0, 4'd8, 0, 64'd0, 1'b0});
    tbl.push_back('{1'b1, 64'(DEPTH - 1), 64'hFFFF_FFFF_FFFF_FF5A, 4'd1, 0, 64'd0, 1'b0});
    tbl.push_back('{1'b0, 64'(DEPTH - 4), 64'd0, 4'd4, 2, 64'h5A00_0000, 1'b0});
    tbl.push_back('{1'b1, 64'h30, 64'hFFFF_FFFF_FFFF_1234, 4'd2, 0, 64'd0, 1'b0});
    tbl.push_back('{1'b0, 64'h30, 64'd0, 4'd8, 0, 64'h1234, 1'b0});

    foreach (tbl[i]) begin
      model(tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].s, r, e);
      xact($sformatf("vec%0d", i), tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].s,
           tbl[i].bp, tbl[i].er, tbl[i].ee);
    end

    for (int n = 0; n < 80; n++) begin
      logic        w;
      logic [63:0] a, d;
      logic [3:0]  s;
      w = 1'($urandom_range(0, 1));
      a = ($urandom_range(0, 5) == 0) ? 64'(DEPTH - 16 + $urandom_range(0, 15))
                                      : 64'($urandom_range(0, 63));
      d = {$urandom, $urandom};
      s = sz_opts[$urandom_range(0, 6)];
      model(w, a, d, s, r, e);
      xact($sformatf("rand%0d", n), w, a, d, s, $urandom_range(0, 2), r, e);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
